dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the mips CPU data port and a read-only

---
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the data memory between the CPU port and the read-only video port
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> rdata  CPU access; cpu_ack pulses one cycle on completion
//   vid_req/addr          -> rdata  video read; vid_ack pulses one cycle on completion
//   mem_req/wr_en/addr/wdata        registered memory strobe, held stable for the whole grant
//   mem_rdata, mem_ack              memory response
//   grant                           01=CPU, 10=video, 00=idle
//   err                             sticky watchdog abort flag
module dmem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ack,
    output logic          mem_req,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    grant,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_VID} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t     state;
    logic       last_vid;
    logic [7:0] cnt;
    logic       cpu_elig, vid_elig, pick_cpu, pick_vid;
    // a request still high during its own ack cycle is the finished access, not a new one
    always_comb begin
        cpu_elig = cpu_req & ~cpu_ack;
        vid_elig = vid_req & ~vid_ack;
        pick_cpu = cpu_elig & (~vid_elig | last_vid);
        pick_vid = vid_elig & ~pick_cpu;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_vid  <= 1'b1;
            cnt       <= '0;
            cpu_rdata <= '0;
            vid_rdata <= '0;
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant     <= 2'b00;
            err       <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_cpu) begin
                        state     <= GNT_CPU;
                        last_vid  <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_wr_en <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        grant     <= 2'b01;
                    end else if (pick_vid) begin
                        state     <= GNT_VID;
                        last_vid  <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_wr_en <= 1'b0;
                        mem_addr  <= vid_addr;
                        mem_wdata <= '0;
                        grant     <= 2'b10;
                    end
                end
                default: begin
                    // mem_ack in the watchdog's final cycle still completes normally
                    if (mem_ack || cnt == LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        mem_req   <= 1'b0;
                        mem_wr_en <= 1'b0;
                        grant     <= 2'b00;
                        if (state == GNT_CPU) cpu_ack <= 1'b1;
                        else vid_ack <= 1'b1;
                        if (mem_ack) begin
                            if (state == GNT_CPU && !mem_wr_en) cpu_rdata <= mem_rdata;
                            if (state == GNT_VID) vid_rdata <= mem_rdata;
                        end else begin
                            err <= 1'b1;
                            if (state == GNT_CPU) cpu_rdata <= '0;
                            else vid_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level memory model
module tb_dmem_arbiter;
    localparam int TIMEOUT = 15;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack, vid_req, vid_ack;
    logic [7:0]  cpu_addr, vid_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata, vid_rdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_wr_en, mem_ack, err;
    logic [1:0]  grant;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem_model [256];
    logic [31:0] cpu_exp, vid_exp;
    bit          err_exp, last_vid;

    dmem_arbiter #(.AW(8), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_req(mem_req), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the first grant cycle; returns at the negedge of the ack cycle.
    // dly = grant cycle in which memory acks (0 = never, watchdog must fire).
    task automatic serve(input bit v, input bit we, input logic [7:0] a, input logic [31:0] d,
                         input int dly, input bit drop);
        int n;
        bit wr;
        logic [31:0] rd;
        wr = !v && we;
        n = (dly == 0) ? TIMEOUT : dly;
        for (int i = 1; i <= n; i++) begin
            chk("mem_req", mem_req, 1);
            chk("grant", grant, v ? 2'b10 : 2'b01);
            chk("mem_addr", mem_addr, a);
            chk("mem_wr_en", mem_wr_en, wr);
            if (wr) chk("mem_wdata", mem_wdata, d);
            chk("ack_early", {cpu_ack, vid_ack}, 0);
            chk("err_hold", err, err_exp);
            if (drop) begin
                if (v) vid_req = 0;
                else cpu_req = 0;
            end
            mem_ack = (i == dly);
            mem_rdata = (i == dly && !wr) ? mem_model[a] : $urandom;
            @(negedge clk);
        end
        mem_ack = 0;
        if (dly == 0) begin
            err_exp = 1;
            rd = 0;
        end else if (wr) begin
            mem_model[a] = d;
            rd = cpu_exp;
        end else begin
            rd = mem_model[a];
        end
        if (v) vid_exp = rd;
        else cpu_exp = rd;
        last_vid = v;
        chk("cpu_ack", cpu_ack, !v);
        chk("vid_ack", vid_ack, v);
        chk("cpu_rdata", cpu_rdata, cpu_exp);
        chk("vid_rdata", vid_rdata, vid_exp);
        chk("ack_mem_req", mem_req, 0);
        chk("ack_wr_en", mem_wr_en, 0);
        chk("ack_grant", grant, 0);
        chk("err", err, err_exp);
    endtask

    task automatic access(input bit v, input bit we, input logic [7:0] a, input logic [31:0] d,
                          input int dly, input bit drop);
        if (v) begin
            vid_req = 1;
            vid_addr = a;
        end else begin
            cpu_req = 1;
            cpu_we = we;
            cpu_addr = a;
            cpu_wdata = d;
        end
        @(negedge clk);
        serve(v, we, a, d, dly, drop);
        cpu_req = 0;
        vid_req = 0;
        @(negedge clk);
        chk("idle_req", mem_req, 0);
        chk("idle_grant", grant, 0);
    endtask

    // Both ports request continuously: grants must alternate starting opposite the last winner.
    task automatic contend(input int n);
        cpu_req = 1;
        vid_req = 1;
        cpu_we = 0;
        cpu_addr = 8'($urandom);
        vid_addr = 8'($urandom);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            bit w;
            w = !last_vid;
            serve(w, 0, w ? vid_addr : cpu_addr, 0, $urandom_range(1, 3), 0);
            if (w) vid_addr = 8'($urandom);
            else cpu_addr = 8'($urandom);
            if (k == n - 1) begin
                cpu_req = 0;
                vid_req = 0;
            end
            @(negedge clk);
        end
        chk("contend_idle", mem_req, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
        reset = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0; mem_rdata = 0; mem_ack = 0;
        cpu_exp = 0; vid_exp = 0; err_exp = 0; last_vid = 1;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_acks", {cpu_ack, vid_ack}, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_err", err, 0);
        reset = 0;
        @(negedge clk);
        // CPU read, memory acks in the first cycle
        mem_model[8'h10] = 32'hCAFEF00D;
        access(0, 0, 8'h10, 0, 1, 0);
        chk("t1_rdata", cpu_rdata, 32'hCAFEF00D);
        // video read so vid_rdata holds a known value, then CPU write
        access(1, 0, 8'h33, 0, 2, 0);
        access(0, 1, 8'h22, 32'h12345678, 1, 0);
        access(0, 0, 8'h22, 0, 1, 0);
        chk("t2_readback", cpu_rdata, 32'h12345678);
        // mem_ack while idle is ignored
        mem_ack = 1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 0;
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_acks", {cpu_ack, vid_ack}, 0);
        chk("idle_ack_rdata", cpu_rdata, cpu_exp);
        // contention alternates
        contend(4);
        // watchdog abort on a video read, then a normal CPU access
        access(1, 0, 8'h55, 0, 0, 0);
        access(0, 0, 8'h56, 0, 2, 0);
        // delayed ack keeps memory-side signals stable
        access(0, 1, 8'h77, 32'hA5A55A5A, 3, 0);
        // request dropped mid-grant still completes
        access(1, 0, 8'h78, 0, 2, 1);
        // reset two cycles into a CPU grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h44;
        @(negedge clk);
        chk("r_grant", grant, 2'b01);
        @(negedge clk);
        reset = 1;
        cpu_req = 0;
        @(negedge clk);
        chk("r_mem_req", mem_req, 0);
        chk("r_grant0", grant, 0);
        chk("r_cpu_ack", cpu_ack, 0);
        chk("r_err", err, 0);
        reset = 0;
        cpu_exp = 0; vid_exp = 0; err_exp = 0; last_vid = 1;
        @(negedge clk);
        chk("r_no_ack", {cpu_ack, vid_ack}, 0);
        contend(2);
        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 2) contend($urandom_range(2, 4));
            else access($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), $urandom,
                        ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4),
                        $urandom_range(0, 3) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
